// File: rtl/rx_word_packer_pkg.sv
// Shared definitions for the RX byte-to-word packer: FSM encoding and lane-index sizing.
package rx_word_packer_pkg;

  typedef enum logic {
    ST_PACK = 1'b0,
    ST_DROP = 1'b1
  } state_e;

  // Width of the lane index for a WD-bit word (at least one bit).
  function automatic int lane_w(input int wd);
    int n;
    n = wd / 8;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_word_packer.sv
// Packs the received byte stream into WD-bit words (first byte in the MSB lane) and feeds
// the RX FIFO through a one-word holding register; frames that would overflow are dropped.
// Handshake: bytes are taken whenever in_valid is high (no backpressure); a FIFO write
// happens in every cycle where wr_en = hold_valid & ~full is high.
module rx_word_packer
  import rx_word_packer_pkg::*;
#(
  parameter int WD = 256,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  input  logic          full,
  output logic          wr_en,
  output logic [WD-1:0] din,
  output logic          frame_done,
  output logic [LW-1:0] frame_len,
  output logic          ovf,
  output logic [LW-1:0] drop_cnt,
  output state_e        dbg_state
);

  localparam int N   = WD / 8;
  localparam int LIW = lane_w(WD);
  localparam logic [LIW-1:0] LAST_LANE = LIW'(N - 1);
  localparam logic [LW-1:0]  CNT_MAX   = '1;

  state_e          state_q;
  logic [LIW-1:0]  lane_q;
  logic [WD-1:0]   acc_q;
  logic [LW-1:0]   cnt_q;
  logic [WD-1:0]   hold_q;
  logic            hold_valid_q;
  logic            hold_last_q;
  logic [LW-1:0]   hold_len_q;
  logic            frame_done_q;
  logic [LW-1:0]   frame_len_q;
  logic            ovf_q;
  logic [LW-1:0]   drop_cnt_q;

  logic [WD-1:0]   word_d;
  logic [LW-1:0]   cnt_d;
  logic            accept;
  logic            complete;
  logic            can_load;
  logic            load;
  logic            overflow;

  assign wr_en      = hold_valid_q & ~full;
  assign din        = hold_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign ovf        = ovf_q;
  assign drop_cnt   = drop_cnt_q;
  assign dbg_state  = state_q;

  always_comb begin
    word_d = acc_q;
    for (int k = 0; k < N; k++) begin
      if (LIW'(k) == lane_q) word_d[WD-1-8*k -: 8] = in_data;
    end
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LW'(1);
    accept   = in_valid & (state_q == ST_PACK);
    complete = accept & (in_last | (lane_q == LAST_LANE));
    // The hold slot is free if empty or being drained on this same edge.
    can_load = ~hold_valid_q | wr_en;
    load     = complete & can_load;
    overflow = complete & ~can_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PACK;
      lane_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_len_q   <= '0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      ovf_q        <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      frame_done_q <= wr_en & hold_last_q;
      if (wr_en & hold_last_q) frame_len_q <= hold_len_q;
      ovf_q <= overflow;
      if (overflow && drop_cnt_q != CNT_MAX) drop_cnt_q <= drop_cnt_q + LW'(1);

      if (load) begin
        hold_q       <= word_d;
        hold_last_q  <= in_last;
        hold_len_q   <= cnt_d;
        hold_valid_q <= 1'b1;
      end else if (wr_en) begin
        hold_valid_q <= 1'b0;
      end

      case (state_q)
        ST_PACK: begin
          if (accept) begin
            if (complete) begin
              lane_q <= '0;
              acc_q  <= '0;
              cnt_q  <= (in_last | overflow) ? '0 : cnt_d;
              if (overflow && !in_last) state_q <= ST_DROP;
            end else begin
              lane_q <= lane_q + LIW'(1);
              acc_q  <= word_d;
              cnt_q  <= cnt_d;
            end
          end
        end
        ST_DROP: begin
          if (in_valid && in_last) begin
            state_q <= ST_PACK;
            lane_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_PACK;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_word_packer.sv
// Bench for rx_word_packer: directed frame table, hand-written corner sequences and random
// traffic, all checked every cycle against a byte-queue reference model.
module tb_rx_word_packer;
  import rx_word_packer_pkg::*;

  localparam int WD = 256;
  localparam int LW = 16;
  localparam int N  = WD / 8;
  localparam int SAT = (1 << LW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_last = 1'b0;
  logic          full = 1'b0;
  logic          wr_en;
  logic [WD-1:0] din;
  logic          frame_done;
  logic [LW-1:0] frame_len;
  logic          ovf;
  logic [LW-1:0] drop_cnt;
  state_e        dbg_state;

  always #5 clk = ~clk;

  rx_word_packer #(.WD(WD), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .full      (full),
    .wr_en     (wr_en),
    .din       (din),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [WD-1:0] exp_q[$];       // words waiting in the hold slot (model)
  bit            exp_last_q[$];
  int            exp_len_q[$];
  logic [7:0]    m_part[$];      // bytes of the word being assembled
  bit            m_dropping;
  int            m_cnt, m_drops, m_flen;
  bit            m_done_p, m_ovf_p;

  logic [WD-1:0] obs_q[$];       // words actually written by the DUT
  int            obs_wr, obs_ovf, obs_done;
  int            cyc;

  task automatic chk(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_last_q.delete();
    exp_len_q.delete();
    m_part.delete();
    m_dropping = 1'b0;
    m_cnt = 0;
    m_drops = 0;
    m_flen = 0;
    m_done_p = 1'b0;
    m_ovf_p = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic f);
    bit            wr;
    bit            lst;
    int            ln;
    logic [WD-1:0] w;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    full     = f;
    #1;
    wr = (exp_q.size() != 0) && !f;
    chk("wr_en", WD'(wr_en), WD'(wr));
    if (wr) chk("din", din, exp_q[0]);
    chk("frame_done", WD'(frame_done), WD'(m_done_p));
    chk("frame_len", WD'(frame_len), WD'(m_flen));
    chk("ovf", WD'(ovf), WD'(m_ovf_p));
    chk("drop_cnt", WD'(drop_cnt), WD'(m_drops));
    chk("state", WD'(dbg_state), WD'(m_dropping ? ST_DROP : ST_PACK));

    if (wr_en) begin
      obs_wr++;
      obs_q.push_back(din);
    end
    if (ovf) obs_ovf++;
    if (frame_done) obs_done++;
    cyc++;

    m_done_p = 1'b0;
    m_ovf_p  = 1'b0;
    if (wr) begin
      void'(exp_q.pop_front());
      lst = exp_last_q.pop_front();
      ln  = exp_len_q.pop_front();
      if (lst) begin
        m_done_p = 1'b1;
        m_flen   = ln;
      end
    end
    if (v) begin
      if (m_dropping) begin
        if (l) m_dropping = 1'b0;
      end else begin
        m_part.push_back(d);
        if (m_cnt < SAT) m_cnt++;
        if (m_part.size() == N || l) begin
          w = '0;
          foreach (m_part[k]) w[WD-1-8*k -: 8] = m_part[k];
          if (exp_q.size() == 0) begin
            exp_q.push_back(w);
            exp_last_q.push_back(l);
            exp_len_q.push_back(m_cnt);
          end else begin
            m_ovf_p = 1'b1;
            if (m_drops < SAT) m_drops++;
            if (!l) m_dropping = 1'b1;
          end
          m_part.delete();
          if (l || m_ovf_p) m_cnt = 0;
        end
      end
    end
  endtask

  // Reset for one cycle; outputs must be at reset values while rst_n is low.
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    full     = 1'b0;
    #1;
    chk("rst wr_en", WD'(wr_en), '0);
    chk("rst din", din, '0);
    chk("rst frame_done", WD'(frame_done), '0);
    chk("rst ovf", WD'(ovf), '0);
    chk("rst drop_cnt", WD'(drop_cnt), '0);
    chk("rst frame_len", WD'(frame_len), '0);
    chk("rst state", WD'(dbg_state), WD'(ST_PACK));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // mode 0: full low, 1: full held high during the frame, 2: full high every 3rd cycle
  task automatic run_frame(input int len, input int mode);
    logic f;
    for (int i = 0; i < len; i++) begin
      f = (mode == 1) ? 1'b1 : (mode == 2) ? ((cyc % 3) == 2) : 1'b0;
      step(1'b1, i[7:0], (i == len - 1), f);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int len;
    int mode;
    int exp_wr;
    int exp_ovf;
    int exp_done;
    int exp_flen;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int            wr0, ovf0, done0;
    logic [WD-1:0] w33;
    logic [WD-1:0] wa;

    model_reset();
    obs_wr = 0; obs_ovf = 0; obs_done = 0; cyc = 0;

    vecs[0] = '{len: 64,  mode: 0, exp_wr: 2, exp_ovf: 0, exp_done: 1, exp_flen: 64};
    vecs[1] = '{len: 33,  mode: 0, exp_wr: 2, exp_ovf: 0, exp_done: 1, exp_flen: 33};
    vecs[2] = '{len: 1,   mode: 0, exp_wr: 1, exp_ovf: 0, exp_done: 1, exp_flen: 1};
    vecs[3] = '{len: 32,  mode: 0, exp_wr: 1, exp_ovf: 0, exp_done: 1, exp_flen: 32};
    vecs[4] = '{len: 100, mode: 1, exp_wr: 1, exp_ovf: 1, exp_done: 0, exp_flen: 32};
    vecs[5] = '{len: 96,  mode: 2, exp_wr: 3, exp_ovf: 0, exp_done: 1, exp_flen: 96};
    vecs[6] = '{len: 65,  mode: 0, exp_wr: 3, exp_ovf: 0, exp_done: 1, exp_flen: 65};

    do_reset();
    drain(2);

    foreach (vecs[r]) begin
      wr0 = obs_wr; ovf0 = obs_ovf; done0 = obs_done;
      obs_q.delete();
      run_frame(vecs[r].len, vecs[r].mode);
      drain(4);
      chk($sformatf("row%0d writes", r), WD'(obs_wr - wr0), WD'(vecs[r].exp_wr));
      chk($sformatf("row%0d ovf", r), WD'(obs_ovf - ovf0), WD'(vecs[r].exp_ovf));
      chk($sformatf("row%0d done", r), WD'(obs_done - done0), WD'(vecs[r].exp_done));
      chk($sformatf("row%0d frame_len", r), WD'(frame_len), WD'(vecs[r].exp_flen));
      chk($sformatf("row%0d state", r), WD'(dbg_state), WD'(ST_PACK));
      if (r == 0 && obs_q.size() >= 2) begin
        chk("64B w0 msb", WD'(obs_q[0][WD-1 -: 8]), WD'(8'h00));
        chk("64B w0 lsb", WD'(obs_q[0][7:0]), WD'(8'h1F));
        chk("64B w1 msb", WD'(obs_q[1][WD-1 -: 8]), WD'(8'h20));
      end
      if (r == 1 && obs_q.size() >= 2) begin
        w33 = '0;
        w33[WD-1 -: 8] = 8'h20;
        chk("33B w1", obs_q[1], w33);
      end
      if (r == 4) chk("held drop_cnt", WD'(drop_cnt), WD'(1));
    end

    // Back-to-back single-byte frames: one write and one frame_done per frame.
    wr0 = obs_wr; done0 = obs_done;
    obs_q.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
    drain(3);
    chk("b2b writes", WD'(obs_wr - wr0), WD'(4));
    chk("b2b done", WD'(obs_done - done0), WD'(4));
    for (int i = 0; i < 4; i++) begin
      wa = '0;
      wa[WD-1 -: 8] = 8'h10 + 8'(i);
      if (obs_q.size() > i) chk($sformatf("b2b word%0d", i), obs_q[i], wa);
    end

    // Reset in the middle of a frame: partial word is lost, next frame starts at lane 0.
    for (int i = 0; i < 10; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    wr0 = obs_wr;
    do_reset();
    obs_q.delete();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) step(1'b1, 8'(i), (i == 4), 1'b0);
    drain(4);
    chk("rst-mid writes", WD'(obs_wr - wr0), WD'(1));
    if (obs_q.size() >= 1) chk("rst-mid msb", WD'(obs_q[0][WD-1 -: 8]), WD'(8'hA5));

    // Random traffic: random lengths, gaps, stalls and FIFO-full patterns.
    for (int fr = 0; fr < 30; fr++) begin
      int len;
      len = $urandom_range(1, 90);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 4) == 0)
          step(1'b0, 8'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3));
        step(1'b1, 8'($urandom), (i == len - 1), ($urandom_range(0, 9) < 3));
      end
      for (int g = $urandom_range(0, 2); g > 0; g--)
        step(1'b0, 8'($urandom), 1'b0, ($urandom_range(0, 9) < 3));
    end
    drain(4);
    chk("final state", WD'(dbg_state), WD'(ST_PACK));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
